// File: rtl/addsub_arb_pkg.sv
// Shared types for the round-robin add/subtract arbiter: FSM encoding and index-width helper.
package addsub_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   localparam int NREQ_DEF = 4;
   localparam int W_DEF    = 4;

   // Index width for a requester count; never below one bit so ports stay legal.
   function automatic int idw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/addsub_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx,
   output logic            any
);

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!any && req[(int'(ptr) + k) % NREQ]) begin
            any                             = 1'b1;
            grant[(int'(ptr) + k) % NREQ]   = 1'b1;
            idx                             = IDW'((int'(ptr) + k) % NREQ);
         end
      end
   end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one ripple add/subtract datapath between NREQ requesters.
//   state | meaning
//   IDLE  | searching for a request from ptr upward; grant is combinational
//   EXEC  | latched operands ripple through the adder; result registered on exit
//   RESP  | result offered to the owner until it accepts
module addsub_arbiter
   import addsub_arb_pkg::*;
#(
   parameter  int NREQ = NREQ_DEF,
   parameter  int W    = W_DEF,
   localparam int IDW  = idw(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_valid,
   output logic [NREQ-1:0] req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ-1:0] req_sub,
   output logic [NREQ-1:0] rsp_valid,
   input  logic [NREQ-1:0] rsp_ready,
   output logic [W:0]      rsp_data,
   output logic [IDW-1:0]  rsp_id,
   output logic            busy
);

   arb_state_t       state_q, state_d;
   logic [IDW-1:0]   ptr_q;
   logic [IDW-1:0]   owner_q;
   logic [W-1:0]     a_q, b_q;
   logic             sub_q;
   logic [W:0]       rsp_data_q;

   logic [NREQ-1:0]  pick_grant;
   logic [IDW-1:0]   pick_idx;
   logic             pick_any;
   logic [NREQ-1:0]  owner_oh;
   logic             load;
   logic             done;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign owner_oh = NREQ'(1) << owner_q;

   // Ripple add/subtract: subtraction is a + ~b + 1, and bit W reports borrow rather than carry.
   logic [W-1:0] b_eff;
   logic [W-1:0] sum;
   logic [W:0]   carry;
   logic [W:0]   result;

   assign b_eff    = b_q ^ {W{sub_q}};
   assign carry[0] = sub_q;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign sum[i]     = a_q[i] ^ b_eff[i] ^ carry[i];
      assign carry[i+1] = (a_q[i] & b_eff[i]) | (carry[i] & (a_q[i] ^ b_eff[i]));
   end

   assign result = {carry[W] ^ sub_q, sum};

   always_comb begin
      state_d   = state_q;
      req_ready = '0;
      rsp_valid = '0;
      busy      = 1'b0;
      load      = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // no grant is shown while reset is pending, since it would be discarded
            if (pick_any && !rst) begin
               req_ready = pick_grant;
               load      = 1'b1;
               state_d   = ST_EXEC;
            end
         end
         ST_EXEC: begin
            busy    = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            busy = 1'b1;
            if (!rst) rsp_valid = owner_oh;
            if (rsp_ready[owner_q]) begin
               done    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         a_q        <= '0;
         b_q        <= '0;
         sub_q      <= 1'b0;
         rsp_data_q <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            a_q     <= req_a[int'(pick_idx)*W +: W];
            b_q     <= req_b[int'(pick_idx)*W +: W];
            sub_q   <= req_sub[pick_idx];
            owner_q <= pick_idx;
         end
         if (state_q == ST_EXEC) rsp_data_q <= result;
         if (done) ptr_q <= (int'(owner_q) == NREQ-1) ? '0 : owner_q + IDW'(1);
      end
   end

   assign rsp_data = rsp_data_q;
   assign rsp_id   = owner_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a cycle-level behavioural model checked on every negedge.
module tb_addsub_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  req_sub;
   logic [3:0]  rsp_valid;
   logic [3:0]  rsp_ready;
   logic [4:0]  rsp_data;
   logic [1:0]  rsp_id;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;
   int grants[$];

   addsub_arbiter #(.NREQ(4), .W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: who owns the datapath, how long since the grant, what the answer must be.
   function automatic int pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++)
         if (v[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic int arith(input int a, input int b, input bit sub);
      if (sub) return ((a - b) & 15) + ((a < b) ? 16 : 0);
      return a + b;
   endfunction

   bit started = 0;
   int m_owner = -1;
   int m_age   = 0;
   int m_ptr   = 0;
   int m_a, m_b, m_data;
   bit m_sub;
   int mg;

   always_comb mg = pick(req_valid, m_ptr);

   always @(posedge clk) begin
      if (rst) begin
         started <= 1'b1;
         m_owner <= -1;
         m_ptr   <= 0;
         m_age   <= 0;
      end else if (started) begin
         if (m_owner < 0) begin
            if (mg >= 0) begin
               m_owner <= mg;
               m_age   <= 1;
               m_a     <= int'(req_a[mg*4 +: 4]);
               m_b     <= int'(req_b[mg*4 +: 4]);
               m_sub   <= req_sub[mg];
            end
         end else if (m_age == 1) begin
            m_data <= arith(m_a, m_b, m_sub);
            m_age  <= 2;
         end else if (rsp_ready[m_owner]) begin
            m_ptr   <= (m_owner + 1) % 4;
            m_owner <= -1;
         end
      end
   end

   always @(negedge clk) begin
      logic [3:0] er, ev;
      if (started && !rst) begin
         er = (m_owner < 0 && mg >= 0) ? (4'b0001 << mg) : 4'b0000;
         ev = (m_owner >= 0 && m_age == 2) ? (4'b0001 << m_owner) : 4'b0000;
         chk("model_req_ready", req_ready, er);
         chk("model_rsp_valid", rsp_valid, ev);
         chk("model_busy", busy, m_owner >= 0);
         if (ev != 0) begin
            chk("model_rsp_data", rsp_data, m_data);
            chk("model_rsp_id", rsp_id, m_owner);
         end
         for (int k = 0; k < 4; k++)
            if (req_ready[k]) grants.push_back(k);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_req(input int idx, input int a, input int b, input bit sub);
      req_a[idx*4 +: 4] = 4'(a);
      req_b[idx*4 +: 4] = 4'(b);
      req_sub[idx]      = sub;
   endtask

   // One complete operation with immediate response acceptance.
   task automatic do_op(input int idx, input logic [3:0] mask, input int a, input int b,
                        input bit sub, input int exp);
      set_req(idx, a, b, sub);
      req_valid = mask;
      @(negedge clk);
      chk("op_grant", req_ready, 4'b0001 << idx);
      tick();
      req_valid = 4'b0000;
      rsp_ready = 4'b0001 << idx;
      tick();
      @(negedge clk);
      chk("op_rsp_valid", rsp_valid, 4'b0001 << idx);
      chk("op_rsp_data", rsp_data, exp);
      chk("op_rsp_id", rsp_id, idx);
      chk("op_busy", busy, 1);
      tick();
      rsp_ready = 4'b0000;
   endtask

   task automatic chk_zero(input string nm);
      @(negedge clk);
      chk({nm, "_rsp_valid"}, rsp_valid, 0);
      chk({nm, "_rsp_data"}, rsp_data, 0);
      chk({nm, "_rsp_id"}, rsp_id, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_req_ready"}, req_ready, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_sub   = '0;
      rsp_ready = '0;
      tick();
      tick();
      rst = 1'b0;
      chk_zero("reset");
      tick();

      do_op(0, 4'b0001, 9, 8, 1'b0, 17);
      do_op(2, 4'b0100, 3, 5, 1'b1, 30);
      do_op(2, 4'b0100, 5, 3, 1'b1, 2);
      do_op(3, 4'b1000, 15, 15, 1'b0, 30);
      // ptr wrapped from 3 to 0, so requester 0 beats requester 3
      do_op(0, 4'b1001, 0, 1, 1'b1, 31);

      // backpressure on requester 1 while requester 2 waits
      set_req(1, 7, 2, 1'b0);
      set_req(2, 6, 6, 1'b1);
      req_valid = 4'b0010;
      @(negedge clk);
      chk("bp_grant", req_ready, 4'b0010);
      tick();
      req_valid = 4'b0100;
      tick();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", rsp_valid, 4'b0010);
         chk("bp_rsp_data", rsp_data, 9);
         chk("bp_req_ready", req_ready, 4'b0000);
         chk("bp_busy", busy, 1);
         tick();
      end
      rsp_ready = 4'b1101;
      @(negedge clk);
      chk("bp_other_ready_ignored", rsp_valid, 4'b0010);
      tick();
      rsp_ready = 4'b0010;
      tick();
      @(negedge clk);
      chk("bp_idle_busy", busy, 0);
      chk("bp_next_grant", req_ready, 4'b0100);
      tick();
      req_valid = 4'b0000;
      rsp_ready = 4'b0100;
      tick();
      @(negedge clk);
      chk("bp2_rsp_valid", rsp_valid, 4'b0100);
      chk("bp2_rsp_data", rsp_data, 0);
      tick();
      rsp_ready = 4'b0000;

      // reset while in EXEC
      set_req(1, 4, 4, 1'b0);
      req_valid = 4'b0010;
      @(negedge clk);
      chk("rx_grant", req_ready, 4'b0010);
      tick();
      req_valid = 4'b0000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_zero("rst_exec");
      for (int i = 0; i < 4; i++) begin
         tick();
         @(negedge clk);
         chk("rst_exec_no_rsp", rsp_valid, 0);
      end
      tick();
      req_valid = 4'b1111;
      @(negedge clk);
      chk("rst_exec_ptr0", req_ready, 4'b0001);

      // reset while in RESP, with a same-cycle rsp_ready
      tick();
      req_valid = 4'b0000;
      tick();
      @(negedge clk);
      chk("rr_rsp_valid", rsp_valid, 4'b0001);
      tick();
      rst       = 1'b1;
      rsp_ready = 4'b0001;
      tick();
      rst       = 1'b0;
      rsp_ready = 4'b0000;
      chk_zero("rst_resp");
      tick();
      req_valid = 4'b1110;
      @(negedge clk);
      chk("rst_resp_ptr0", req_ready, 4'b0010);
      rst       = 1'b1;
      req_valid = 4'b0000;
      tick();

      // all four requesting continuously from reset
      tick();
      for (int i = 0; i < 4; i++) set_req(i, i, 1, 1'b0);
      grants.delete();
      rst       = 1'b0;
      req_valid = 4'b1111;
      rsp_ready = 4'b1111;
      for (int c = 0; c < 40 && grants.size() < 5; c++) tick();
      chk("rr_grant_count", grants.size(), 5);
      if (grants.size() >= 5) begin
         chk("rr_grant0", grants[0], 0);
         chk("rr_grant1", grants[1], 1);
         chk("rr_grant2", grants[2], 2);
         chk("rr_grant3", grants[3], 3);
         chk("rr_grant4", grants[4], 0);
      end
      req_valid = 4'b0000;
      repeat (4) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
